// File: rtl/subneg_bus_pkg.sv
// Shared constants for the SUBNEG external memory bus: data width, the
// output-port address and the idle levels of the core's bus strobes.
package subneg_bus_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] OUT_ADDR = 8'hFF;

  // Idle (reset) levels of the core strobes
  localparam logic LATCH_IDLE = 1'b0;
  localparam logic WE_N_IDLE  = 1'b1;
  localparam logic OE_N_IDLE  = 1'b1;
  localparam logic OUT_IDLE   = 1'b0;

endpackage : subneg_bus_pkg

// File: rtl/subneg_edge_det.sv
// One-bit edge detector: registered history of a level sampled in the clk
// domain, reset to a configurable idle level so no edge fires out of reset.
module subneg_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise,
  output logic fall
);

  logic hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= RST_VAL;
    end else begin
      hist_q <= d_i;
    end
  end

  assign rise = d_i & ~hist_q;
  assign fall = ~d_i & hist_q;

endmodule : subneg_edge_det

// File: rtl/subneg_mem_responder.sv
// Memory-side responder for the SUBNEG core: address latch, flop-array SRAM,
// output latch, plus a host load port usable while the core is held off.
module subneg_mem_responder
  import subneg_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                latch_clk_i,
  input  logic                oe_n_i,
  input  logic                we_n_i,
  input  logic                out_clk_i,
  input  logic [DATA_W-1:0]   bus_i,
  output logic [DATA_W-1:0]   bus_o,
  output logic                bus_oe,
  output logic [DATA_W-1:0]   out_q,
  input  logic                ld_en,
  input  logic                ld_we,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_wdata,
  output logic [DATA_W-1:0]   ld_rdata,
  output logic [7:0]          wr_count,
  output logic                err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] out_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic              err_q, err_d;

  logic              latch_rise, latch_fall;
  logic              we_rise, we_fall;
  logic              out_rise, out_fall;

  logic              core_wr_c;
  logic              host_wr_c;
  logic [ADDR_W-1:0] idx_c;

  subneg_edge_det #(.RST_VAL(LATCH_IDLE)) u_latch_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (latch_clk_i),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  subneg_edge_det #(.RST_VAL(WE_N_IDLE)) u_we_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (we_n_i),
    .rise  (we_rise),
    .fall  (we_fall)
  );

  subneg_edge_det #(.RST_VAL(OUT_IDLE)) u_out_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (out_clk_i),
    .rise  (out_rise),
    .fall  (out_fall)
  );

  assign idx_c = addr_q[ADDR_W-1:0];

  // Next-state for the core-side registers; every event uses the pre-edge addr_q
  always_comb begin
    addr_d     = addr_q;
    out_d      = out_q;
    wr_count_d = wr_count_q;
    err_d      = err_q;
    core_wr_c  = 1'b0;
    host_wr_c  = ld_en & ld_we;

    if (!ld_en) begin
      if (latch_rise) begin
        addr_d = bus_i;
      end
      if (out_rise) begin
        out_d = bus_i;
      end
      if (we_fall) begin
        if (oe_n_i) begin
          core_wr_c  = 1'b1;
          wr_count_d = wr_count_q + 8'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      out_q      <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      out_q      <= out_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
    end
  end

  // Host and core writes are mutually exclusive: core writes require ld_en low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (host_wr_c) begin
      mem_q[ld_addr] <= ld_wdata;
    end else if (core_wr_c) begin
      mem_q[idx_c] <= bus_i;
    end
  end

  assign bus_oe   = ~oe_n_i;
  assign bus_o    = mem_q[idx_c];
  assign ld_rdata = mem_q[ld_addr];
  assign wr_count = wr_count_q;
  assign err      = err_q;

  logic unused_c;
  assign unused_c = ^{latch_fall, we_rise, out_fall, addr_q};

endmodule : subneg_mem_responder

// File: tb/tb_subneg_mem_responder.sv
// Directed bench for subneg_mem_responder with hand-computed expectations.
module tb_subneg_mem_responder;
  import subneg_bus_pkg::*;

  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              latch_clk_i;
  logic              oe_n_i;
  logic              we_n_i;
  logic              out_clk_i;
  logic [7:0]        bus_i;
  logic [7:0]        bus_o;
  logic              bus_oe;
  logic [7:0]        out_q;
  logic              ld_en;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_wdata;
  logic [7:0]        ld_rdata;
  logic [7:0]        wr_count;
  logic              err;

  int n_checks;
  int n_pass;

  subneg_mem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .latch_clk_i (latch_clk_i),
    .oe_n_i      (oe_n_i),
    .we_n_i      (we_n_i),
    .out_clk_i   (out_clk_i),
    .bus_i       (bus_i),
    .bus_o       (bus_o),
    .bus_oe      (bus_oe),
    .out_q       (out_q),
    .ld_en       (ld_en),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_wdata    (ld_wdata),
    .ld_rdata    (ld_rdata),
    .wr_count    (wr_count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    latch_clk_i = LATCH_IDLE;
    oe_n_i      = OE_N_IDLE;
    we_n_i      = WE_N_IDLE;
    out_clk_i   = OUT_IDLE;
    bus_i       = 8'h00;
    ld_en       = 1'b0;
    ld_we       = 1'b0;
    ld_addr     = '0;
    ld_wdata    = 8'h00;
    step(3);
    rst_n = 1'b1;
    step(1);

    check("rst_out_q", 32'(out_q), 32'h00);
    check("rst_wr_count", 32'(wr_count), 32'h00);
    check("rst_err", 32'(err), 32'h0);
    check("rst_bus_oe", 32'(bus_oe), 32'h0);
    check("rst_bus_o", 32'(bus_o), 32'h00);

    // host preload mem[3] = 0x5A
    ld_en = 1'b1; ld_we = 1'b1; ld_addr = 5'd3; ld_wdata = 8'h5A;
    step(1);
    ld_we = 1'b0;
    check("host_rdback", 32'(ld_rdata), 32'h5A);
    ld_en = 1'b0;
    step(1);

    // core read: latch 0x03, then OE low
    bus_i = 8'h03; latch_clk_i = 1'b1;
    step(1);
    oe_n_i = 1'b0;
    #1;
    check("rd_bus_oe_same", 32'(bus_oe), 32'h1);
    check("rd_bus_o_same", 32'(bus_o), 32'h5A);
    step(1);
    check("rd_bus_o_next", 32'(bus_o), 32'h5A);
    oe_n_i = 1'b1; latch_clk_i = 1'b0;
    #1;
    check("rd_bus_oe_off", 32'(bus_oe), 32'h0);
    step(1);

    // write 0x77 to address 4 with a 3-cycle WE pulse
    bus_i = 8'h04; latch_clk_i = 1'b1;
    step(1);
    latch_clk_i = 1'b0; bus_i = 8'h77; we_n_i = 1'b0;
    step(3);
    we_n_i = 1'b1;
    step(1);
    check("wr_count_once", 32'(wr_count), 32'h01);
    ld_addr = 5'd4;
    check("wr_mem4", 32'(ld_rdata), 32'h77);
    check("wr_bus_o", 32'(bus_o), 32'h77);

    // output latch
    bus_i = 8'hC3; out_clk_i = 1'b1;
    step(1);
    out_clk_i = 1'b0; bus_i = 8'h00;
    step(1);
    check("out_q_c3", 32'(out_q), 32'hC3);
    check("out_mem4_kept", 32'(ld_rdata), 32'h77);
    ld_addr = 5'd3;
    check("out_mem3_kept", 32'(ld_rdata), 32'h5A);
    step(2);
    check("out_q_hold", 32'(out_q), 32'hC3);

    // WE falling while OE low -> contention
    oe_n_i = 1'b0; bus_i = 8'h99; we_n_i = 1'b0;
    step(1);
    we_n_i = 1'b1; oe_n_i = 1'b1;
    step(1);
    check("cont_err", 32'(err), 32'h1);
    ld_addr = 5'd4;
    check("cont_mem4", 32'(ld_rdata), 32'h77);
    check("cont_wr_count", 32'(wr_count), 32'h01);
    step(4);
    check("cont_err_sticky", 32'(err), 32'h1);

    // host owns memory: core strobes ignored
    ld_en = 1'b1; bus_i = 8'h0A; latch_clk_i = 1'b1;
    step(1);
    latch_clk_i = 1'b0; bus_i = 8'hBB; we_n_i = 1'b0;
    step(1);
    we_n_i = 1'b1; out_clk_i = 1'b1;
    step(1);
    out_clk_i = 1'b0;
    step(1);
    check("ld_no_addr", 32'(bus_o), 32'h77);
    ld_addr = 5'd10;
    check("ld_no_wr_mem", 32'(ld_rdata), 32'h00);
    check("ld_no_wr_cnt", 32'(wr_count), 32'h01);
    check("ld_no_out", 32'(out_q), 32'hC3);
    // ld_en falls with latch already high: no stale capture
    bus_i = 8'h0A; latch_clk_i = 1'b1;
    step(1);
    ld_en = 1'b0;
    step(2);
    check("ld_no_stale", 32'(bus_o), 32'h77);
    latch_clk_i = 1'b0;
    step(1);

    // address 0x25 wraps to index 5
    bus_i = 8'h25; latch_clk_i = 1'b1;
    step(1);
    latch_clk_i = 1'b0; bus_i = 8'h3C; we_n_i = 1'b0;
    step(1);
    we_n_i = 1'b1;
    step(1);
    ld_addr = 5'd5;
    check("wrap_mem5", 32'(ld_rdata), 32'h3C);
    check("wrap_wr_count", 32'(wr_count), 32'h02);

    // latch + write in one cycle: write uses old address (idx 5)
    bus_i = OUT_ADDR; latch_clk_i = 1'b1; we_n_i = 1'b0;
    step(1);
    we_n_i = 1'b1; latch_clk_i = 1'b0;
    step(1);
    check("simul_old_addr", 32'(ld_rdata), 32'hFF);
    check("simul_cnt", 32'(wr_count), 32'h03);
    check("simul_new_addr", 32'(bus_o), 32'h00);

    // core write to 0xFF aliases to mem[31]
    bus_i = 8'hE1; we_n_i = 1'b0;
    step(1);
    we_n_i = 1'b1;
    step(1);
    ld_addr = 5'd31;
    check("alias_mem31", 32'(ld_rdata), 32'hE1);
    check("alias_bus_o", 32'(bus_o), 32'hE1);
    check("alias_cnt", 32'(wr_count), 32'h04);

    // reset pulsed mid-write
    bus_i = 8'h11; we_n_i = 1'b0;
    step(1);
    rst_n = 1'b0;
    #2;
    ld_addr = 5'd5;
    check("midrst_mem5", 32'(ld_rdata), 32'h00);
    check("midrst_out_q", 32'(out_q), 32'h00);
    check("midrst_wr_count", 32'(wr_count), 32'h00);
    check("midrst_err", 32'(err), 32'h0);
    check("midrst_bus_o", 32'(bus_o), 32'h00);
    we_n_i = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(2);
    check("post_rst_err", 32'(err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_subneg_mem_responder
